// File: rtl/sprite_layer_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sprite_layer_arbiter_pkg
// Shared constants and types for the sprite layer arbiter:
//   - palette index constants (transparent index, highest legal index)
//   - 12-bit RRRRGGGGBBBB palette colours, the illegal-index colour and
//     the flash colour
//   - flash state machine encoding (used only when SPRITE_FLASH_EN is defined)
//   - helper to classify an index as illegal
// ---------------------------------------------------------------------------
package sprite_layer_arbiter_pkg;

    localparam logic [3:0] IDX_TRANSPARENT = 4'd0;
    localparam logic [3:0] IDX_MAX_LEGAL   = 4'd8;

    // Palette; indices 1 and 2 have a team-B variant.
    localparam logic [11:0] PAL_1_A     = 12'hD42;
    localparam logic [11:0] PAL_1_B     = 12'h8DF;
    localparam logic [11:0] PAL_2_A     = 12'h921;
    localparam logic [11:0] PAL_2_B     = 12'h009;
    localparam logic [11:0] PAL_3       = 12'hFF9;
    localparam logic [11:0] PAL_4       = 12'h210;
    localparam logic [11:0] PAL_5       = 12'h778;
    localparam logic [11:0] PAL_6       = 12'h6B4;
    localparam logic [11:0] PAL_7       = 12'hDD0;
    localparam logic [11:0] PAL_8       = 12'hFFF;
    localparam logic [11:0] RGB_ILLEGAL = 12'hF0F;
    localparam logic [11:0] RGB_BLACK   = 12'h000;
    localparam logic [11:0] RGB_FLASH   = 12'hFFF;

    typedef enum logic [1:0] {
        FL_IDLE  = 2'd0,
        FL_ARMED = 2'd1,
        FL_FLASH = 2'd2
    } flash_state_e;

    function automatic logic is_illegal_idx(input logic [3:0] idx);
        return idx > IDX_MAX_LEGAL;
    endfunction

endpackage

// File: rtl/sprite_layer_arbiter_palette_lut.sv
// ---------------------------------------------------------------------------
// palette_lut
// Purely combinational palette: maps a 4-bit palette index and the team-B
// flag to a 12-bit RRRRGGGGBBBB colour. Indices above the legal range map to
// the illegal colour so they are obvious on screen.
// Ports:
//   idx   in  4   palette index (0 is transparent and never reaches here
//                 as a winner; it maps to black)
//   is_b  in  1   team-B flag, only affects indices 1 and 2
//   rgb   out 12  colour
// ---------------------------------------------------------------------------
module palette_lut
    import sprite_layer_arbiter_pkg::*;
(
    input  logic [3:0]  idx,
    input  logic        is_b,
    output logic [11:0] rgb
);

    always_comb begin
        rgb = RGB_ILLEGAL;
        case (idx)
            4'd0:    rgb = RGB_BLACK;
            4'd1:    rgb = is_b ? PAL_1_B : PAL_1_A;
            4'd2:    rgb = is_b ? PAL_2_B : PAL_2_A;
            4'd3:    rgb = PAL_3;
            4'd4:    rgb = PAL_4;
            4'd5:    rgb = PAL_5;
            4'd6:    rgb = PAL_6;
            4'd7:    rgb = PAL_7;
            4'd8:    rgb = PAL_8;
            default: rgb = RGB_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/sprite_layer_arbiter.sv
// ---------------------------------------------------------------------------
// sprite_layer_arbiter
// Per-pixel compositor between the layer fetch units and the VGA output.
// Three-stage pipeline advancing on pix_en:
//   A capture : registers layer indices, team flags and sync timing
//   B select  : lowest-numbered non-transparent layer wins
//   C colour  : palette lookup / background / blanking, plus the per-frame
//               illegal-index counter
// Optional feature, enabled by defining SPRITE_FLASH_EN: a flash state
// machine that makes one layer's pixels white on alternate frames.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   pix_en                       pixel strobe
//   layer_idx [4*NUM_LAYERS]     palette index per layer (layer i at [4i+3:4i])
//   layer_is_b [NUM_LAYERS]      team-B flag per layer
//   bg_rgb [12]                  background colour, sampled at stage C
//   video_on_in/hsync_in/vsync_in  timing in (syncs active-low)
//   flash_req, flash_layer       flash request (SPRITE_FLASH_EN only)
//   rgb_out [12]                 pixel colour
//   video_on_out/hsync_out/vsync_out  timing aligned with rgb_out
//   win_layer, win_valid         winning layer and whether any layer won
//   bad_cnt_frame [8]            illegal-index count of the previous frame
//   flash_busy                   flash machine not idle
// ---------------------------------------------------------------------------
module sprite_layer_arbiter
    import sprite_layer_arbiter_pkg::*;
#(
    parameter int NUM_LAYERS   = 4,
    parameter int LAYER_W      = 2,
    parameter int FLASH_FRAMES = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pix_en,
    input  logic [4*NUM_LAYERS-1:0] layer_idx,
    input  logic [NUM_LAYERS-1:0]   layer_is_b,
    input  logic [11:0]             bg_rgb,
    input  logic                    video_on_in,
    input  logic                    hsync_in,
    input  logic                    vsync_in,
    input  logic                    flash_req,
    input  logic [LAYER_W-1:0]      flash_layer,
    output logic [11:0]             rgb_out,
    output logic                    video_on_out,
    output logic                    hsync_out,
    output logic                    vsync_out,
    output logic [LAYER_W-1:0]      win_layer,
    output logic                    win_valid,
    output logic [7:0]              bad_cnt_frame,
    output logic                    flash_busy
);

    // ---------------- Stage A: capture ----------------
    logic [4*NUM_LAYERS-1:0] a_idx_q, a_idx_d;
    logic [NUM_LAYERS-1:0]   a_is_b_q, a_is_b_d;
    logic                    a_von_q, a_von_d;
    logic                    a_hs_q, a_hs_d;
    logic                    a_vs_q, a_vs_d;

    always_comb begin
        a_idx_d  = a_idx_q;
        a_is_b_d = a_is_b_q;
        a_von_d  = a_von_q;
        a_hs_d   = a_hs_q;
        a_vs_d   = a_vs_q;
        if (pix_en) begin
            a_idx_d  = layer_idx;
            a_is_b_d = layer_is_b;
            a_von_d  = video_on_in;
            a_hs_d   = hsync_in;
            a_vs_d   = vsync_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_idx_q  <= '0;
            a_is_b_q <= '0;
            a_von_q  <= 1'b0;
            a_hs_q   <= 1'b1;
            a_vs_q   <= 1'b1;
        end else begin
            a_idx_q  <= a_idx_d;
            a_is_b_q <= a_is_b_d;
            a_von_q  <= a_von_d;
            a_hs_q   <= a_hs_d;
            a_vs_q   <= a_vs_d;
        end
    end

    // ---------------- Stage B: select ----------------
    logic [3:0]            a_idx_arr [NUM_LAYERS];
    logic [NUM_LAYERS-1:0] a_opaque;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer
            assign a_idx_arr[gi] = a_idx_q[4*gi +: 4];
            assign a_opaque[gi]  = (a_idx_arr[gi] != IDX_TRANSPARENT);
        end
    endgenerate

    logic               sel_valid;
    logic [LAYER_W-1:0] sel_layer;
    logic [3:0]         sel_idx;
    logic               sel_is_b;

    // Scan from the lowest priority upward so the lowest opaque layer
    // is the last assignment and therefore the winner.
    always_comb begin
        sel_valid = 1'b0;
        sel_layer = '0;
        sel_idx   = IDX_TRANSPARENT;
        sel_is_b  = 1'b0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (a_opaque[i]) begin
                sel_valid = 1'b1;
                sel_layer = LAYER_W'(i);
                sel_idx   = a_idx_arr[i];
                sel_is_b  = a_is_b_q[i];
            end
        end
    end

    logic               b_valid_q, b_valid_d;
    logic [LAYER_W-1:0] b_layer_q, b_layer_d;
    logic [3:0]         b_idx_q, b_idx_d;
    logic               b_is_b_q, b_is_b_d;
    logic               b_von_q, b_von_d;
    logic               b_hs_q, b_hs_d;
    logic               b_vs_q, b_vs_d;

    always_comb begin
        b_valid_d = b_valid_q;
        b_layer_d = b_layer_q;
        b_idx_d   = b_idx_q;
        b_is_b_d  = b_is_b_q;
        b_von_d   = b_von_q;
        b_hs_d    = b_hs_q;
        b_vs_d    = b_vs_q;
        if (pix_en) begin
            b_valid_d = sel_valid;
            b_layer_d = sel_layer;
            b_idx_d   = sel_idx;
            b_is_b_d  = sel_is_b;
            b_von_d   = a_von_q;
            b_hs_d    = a_hs_q;
            b_vs_d    = a_vs_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_valid_q <= 1'b0;
            b_layer_q <= '0;
            b_idx_q   <= IDX_TRANSPARENT;
            b_is_b_q  <= 1'b0;
            b_von_q   <= 1'b0;
            b_hs_q    <= 1'b1;
            b_vs_q    <= 1'b1;
        end else begin
            b_valid_q <= b_valid_d;
            b_layer_q <= b_layer_d;
            b_idx_q   <= b_idx_d;
            b_is_b_q  <= b_is_b_d;
            b_von_q   <= b_von_d;
            b_hs_q    <= b_hs_d;
            b_vs_q    <= b_vs_d;
        end
    end

    // ---------------- Stage C: colour ----------------
    logic [11:0] lut_rgb;

    palette_lut u_palette_lut (
        .idx  (b_idx_q),
        .is_b (b_is_b_q),
        .rgb  (lut_rgb)
    );

    logic [11:0]        c_rgb_q, c_rgb_d;
    logic               c_von_q, c_von_d;
    logic               c_hs_q, c_hs_d;
    logic               c_vs_q, c_vs_d;
    logic [LAYER_W-1:0] c_layer_q, c_layer_d;
    logic               c_valid_q, c_valid_d;
    logic [7:0]         bad_cnt_q, bad_cnt_d;
    logic [7:0]         bad_frame_q, bad_frame_d;

    logic flash_hit;
    logic vs_fall;
    logic pix_illegal;

    // Frame boundary as seen at stage C: vsync entering C goes low while
    // the value already in C is high.
    assign vs_fall     = pix_en & c_vs_q & ~b_vs_q;
    assign pix_illegal = pix_en & b_von_q & b_valid_q & is_illegal_idx(b_idx_q);

    always_comb begin
        c_rgb_d     = c_rgb_q;
        c_von_d     = c_von_q;
        c_hs_d      = c_hs_q;
        c_vs_d      = c_vs_q;
        c_layer_d   = c_layer_q;
        c_valid_d   = c_valid_q;
        bad_cnt_d   = bad_cnt_q;
        bad_frame_d = bad_frame_q;
        if (pix_en) begin
            c_von_d   = b_von_q;
            c_hs_d    = b_hs_q;
            c_vs_d    = b_vs_q;
            c_layer_d = b_layer_q;
            c_valid_d = b_valid_q;
            if (!b_von_q) begin
                c_rgb_d = RGB_BLACK;
            end else if (!b_valid_q) begin
                c_rgb_d = bg_rgb;
            end else if (flash_hit) begin
                c_rgb_d = RGB_FLASH;
            end else begin
                c_rgb_d = lut_rgb;
            end
        end
        // The pixel carrying the frame edge belongs to the new frame.
        if (vs_fall) begin
            bad_frame_d = bad_cnt_q;
            bad_cnt_d   = pix_illegal ? 8'd1 : 8'd0;
        end else if (pix_illegal && (bad_cnt_q != 8'hFF)) begin
            bad_cnt_d = bad_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_rgb_q     <= RGB_BLACK;
            c_von_q     <= 1'b0;
            c_hs_q      <= 1'b1;
            c_vs_q      <= 1'b1;
            c_layer_q   <= '0;
            c_valid_q   <= 1'b0;
            bad_cnt_q   <= 8'd0;
            bad_frame_q <= 8'd0;
        end else begin
            c_rgb_q     <= c_rgb_d;
            c_von_q     <= c_von_d;
            c_hs_q      <= c_hs_d;
            c_vs_q      <= c_vs_d;
            c_layer_q   <= c_layer_d;
            c_valid_q   <= c_valid_d;
            bad_cnt_q   <= bad_cnt_d;
            bad_frame_q <= bad_frame_d;
        end
    end

    // ---------------- Flash feature ----------------
`ifdef SPRITE_FLASH_EN
    flash_state_e       fl_state_q, fl_state_d;
    logic [LAYER_W-1:0] fl_layer_q, fl_layer_d;
    logic [7:0]         frm_cnt_q, frm_cnt_d;

    // Runs every clock; only the frame edge is tied to the pixel strobe.
    // A new request always wins and restarts from ARMED.
    always_comb begin
        fl_state_d = fl_state_q;
        fl_layer_d = fl_layer_q;
        frm_cnt_d  = frm_cnt_q;
        if (flash_req) begin
            fl_state_d = FL_ARMED;
            fl_layer_d = flash_layer;
        end else begin
            case (fl_state_q)
                FL_ARMED: begin
                    if (vs_fall) begin
                        fl_state_d = FL_FLASH;
                        frm_cnt_d  = 8'(FLASH_FRAMES);
                    end
                end
                FL_FLASH: begin
                    if (vs_fall) begin
                        frm_cnt_d = frm_cnt_q - 8'd1;
                        if (frm_cnt_q <= 8'd1) begin
                            fl_state_d = FL_IDLE;
                            frm_cnt_d  = 8'd0;
                        end
                    end
                end
                default: fl_state_d = FL_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fl_state_q <= FL_IDLE;
            fl_layer_q <= '0;
            frm_cnt_q  <= 8'd0;
        end else begin
            fl_state_q <= fl_state_d;
            fl_layer_q <= fl_layer_d;
            frm_cnt_q  <= frm_cnt_d;
        end
    end

    // Odd frame counts are the white frames.
    assign flash_hit  = (fl_state_q == FL_FLASH) && frm_cnt_q[0] && b_valid_q
                        && (b_layer_q == fl_layer_q);
    assign flash_busy = (fl_state_q != FL_IDLE);
`else
    logic unused_flash_inputs;
    assign unused_flash_inputs = ^{flash_req, flash_layer};
    assign flash_hit  = 1'b0;
    assign flash_busy = 1'b0;
`endif

    assign rgb_out       = c_rgb_q;
    assign video_on_out  = c_von_q;
    assign hsync_out     = c_hs_q;
    assign vsync_out     = c_vs_q;
    assign win_layer     = c_layer_q;
    assign win_valid     = c_valid_q;
    assign bad_cnt_frame = bad_frame_q;

endmodule

// File: tb/tb_sprite_layer_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sprite_layer_arbiter
// Table of pixel vectors with hand-derived expected colours, pushed into a
// scoreboard queue when driven and compared three strobes later, plus
// sequences for stalls, the illegal counter, flashing and mid-line reset.
// Build with SPRITE_FLASH_EN defined to exercise the flash machine.
// ---------------------------------------------------------------------------
module tb_sprite_layer_arbiter;

`ifdef SPRITE_FLASH_EN
    localparam bit FLASH_ON = 1'b1;
`else
    localparam bit FLASH_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_en;
    logic [15:0] layer_idx;
    logic [3:0]  layer_is_b;
    logic [11:0] bg_rgb;
    logic        video_on_in, hsync_in, vsync_in;
    logic        flash_req;
    logic [1:0]  flash_layer;
    logic [11:0] rgb_out;
    logic        video_on_out, hsync_out, vsync_out;
    logic [1:0]  win_layer;
    logic        win_valid;
    logic [7:0]  bad_cnt_frame;
    logic        flash_busy;

    sprite_layer_arbiter #(
        .NUM_LAYERS   (4),
        .LAYER_W      (2),
        .FLASH_FRAMES (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pix_en        (pix_en),
        .layer_idx     (layer_idx),
        .layer_is_b    (layer_is_b),
        .bg_rgb        (bg_rgb),
        .video_on_in   (video_on_in),
        .hsync_in      (hsync_in),
        .vsync_in      (vsync_in),
        .flash_req     (flash_req),
        .flash_layer   (flash_layer),
        .rgb_out       (rgb_out),
        .video_on_out  (video_on_out),
        .hsync_out     (hsync_out),
        .vsync_out     (vsync_out),
        .win_layer     (win_layer),
        .win_valid     (win_valid),
        .bad_cnt_frame (bad_cnt_frame),
        .flash_busy    (flash_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] rgb;
        logic        use_bg;
        logic        von;
        logic        hs;
        logic        vs;
        logic [1:0]  wl;
        logic        wv;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [15:0] idx;
        logic [3:0]  isb;
        logic        von;
        logic        hs;
        logic        vs;
        logic [11:0] bg;
        logic [11:0] exp_rgb;
        logic        exp_use_bg;
        logic [1:0]  exp_wl;
        logic        exp_wv;
        logic        exp_ill;
    } vec_t;

    exp_t        sb[$];
    vec_t        tbl[19];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [11:0] cur_bg;
    logic [25:0] last_exp;
    int          m_bad_cnt, m_bad_frame;
    logic        m_prev_out_vs;
    int          m_fstate, m_fcnt;

    function automatic exp_t mk(input logic [11:0] rgb, input logic use_bg,
                                input logic von, input logic hs, input logic vs,
                                input logic [1:0] wl, input logic wv, input logic ill);
        exp_t e;
        e.rgb = rgb; e.use_bg = use_bg; e.von = von; e.hs = hs; e.vs = vs;
        e.wl = wl; e.wv = wv; e.ill = ill;
        return e;
    endfunction

    function automatic logic [25:0] dut_vec();
        return {rgb_out, video_on_out, hsync_out, vsync_out, win_layer, win_valid, bad_cnt_frame};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%h required=%h", name, act, req);
    endtask

    task automatic model_reset();
        sb.delete();
        // Two idle stages (A and B) drain out before the first real pixel.
        sb.push_back(mk(12'h000, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0));
        sb.push_back(mk(12'h000, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0));
        m_bad_cnt = 0; m_bad_frame = 0; m_prev_out_vs = 1'b1;
        m_fstate = 0; m_fcnt = 0;
    endtask

    task automatic pop_check(input string name, input bit verbose);
        exp_t        e;
        logic [11:0] rgb;
        if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL %s: actual=scoreboard empty required=pending entry", name);
            return;
        end
        e = sb.pop_front();
        if (m_prev_out_vs && !e.vs) begin
            m_bad_frame = m_bad_cnt;
            m_bad_cnt   = e.ill ? 1 : 0;
        end else if (e.ill && m_bad_cnt < 255) begin
            m_bad_cnt++;
        end
        m_prev_out_vs = e.vs;
        rgb = e.use_bg ? cur_bg : e.rgb;
        last_exp = {rgb, e.von, e.hs, e.vs, e.wl, e.wv, 8'(m_bad_frame)};
        check(name, 32'(dut_vec()), 32'(last_exp));
        if (verbose)
            $display("pix %s rgb=%h hs=%b vs=%b von=%b win=%0d/%b bad_frame=%0d",
                     name, rgb_out, hsync_out, vsync_out, video_on_out,
                     win_layer, win_valid, bad_cnt_frame);
    endtask

    task automatic strobe(input logic [15:0] idx, input logic [3:0] isb,
                          input logic von, input logic hs, input logic vs,
                          input logic [11:0] bg, input exp_t e,
                          input string name, input bit verbose);
        layer_idx = idx; layer_is_b = isb;
        video_on_in = von; hsync_in = hs; vsync_in = vs;
        bg_rgb = bg; cur_bg = bg;
        pix_en = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        pop_check(name, verbose);
    endtask

    task automatic blank(input int n, input logic vs);
        for (int k = 0; k < n; k++)
            strobe(16'h0000, 4'h0, 1'b0, 1'b1, vs, cur_bg,
                   mk(12'h000, 1'b0, 1'b0, 1'b1, vs, 2'd0, 1'b0, 1'b0), "blank", 1'b0);
    endtask

    // Visible pixels then a blanked vsync pulse; the flash model tracks
    // the machine in input order so each pixel knows its expected colour.
    task automatic flash_frame(input int f);
        logic flash_now;
        flash_now = (m_fstate == 2) && (m_fcnt % 2 == 1);
        strobe(16'h0300, 4'h0, 1'b1, 1'b1, 1'b1, cur_bg,
               mk(flash_now ? 12'hFFF : 12'hFF9, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0),
               $sformatf("flash_f%0d_l2a", f), 1'b1);
        strobe(16'h0050, 4'h0, 1'b1, 1'b1, 1'b1, cur_bg,
               mk(12'h778, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0),
               $sformatf("flash_f%0d_l1", f), 1'b1);
        strobe(16'h0300, 4'h0, 1'b1, 1'b1, 1'b1, cur_bg,
               mk(flash_now ? 12'hFFF : 12'hFF9, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0),
               $sformatf("flash_f%0d_l2b", f), 1'b1);
        blank(1, 1'b1);
        blank(1, 1'b0);
        if (m_fstate == 1) begin
            m_fstate = 2; m_fcnt = 4;
        end else if (m_fstate == 2) begin
            m_fcnt--;
            if (m_fcnt == 0) m_fstate = 0;
        end
        blank(1, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: actual=no finish required=finish within 500us");
        $fatal(1, "timeout");
    end

    initial begin
        //         idx       isb   von   hs    vs    bg       rgb      bg?   wl    wv    ill
        tbl[0]  = '{16'h0000, 4'h0, 1'b1, 1'b1, 1'b1, 12'h123, 12'h000, 1'b1, 2'd0, 1'b0, 1'b0};
        tbl[1]  = '{16'h0000, 4'h0, 1'b1, 1'b1, 1'b1, 12'h123, 12'h000, 1'b1, 2'd0, 1'b0, 1'b0};
        tbl[2]  = '{16'h0000, 4'h0, 1'b1, 1'b1, 1'b1, 12'h123, 12'h000, 1'b1, 2'd0, 1'b0, 1'b0};
        tbl[3]  = '{16'h1520, 4'h2, 1'b1, 1'b1, 1'b1, 12'h123, 12'h009, 1'b0, 2'd1, 1'b1, 1'b0};
        tbl[4]  = '{16'h1520, 4'h0, 1'b1, 1'b1, 1'b1, 12'h123, 12'h921, 1'b0, 2'd1, 1'b1, 1'b0};
        tbl[5]  = '{16'h0001, 4'h1, 1'b1, 1'b1, 1'b1, 12'h123, 12'h8DF, 1'b0, 2'd0, 1'b1, 1'b0};
        tbl[6]  = '{16'h3000, 4'h8, 1'b1, 1'b1, 1'b1, 12'h123, 12'hFF9, 1'b0, 2'd3, 1'b1, 1'b0};
        tbl[7]  = '{16'h0400, 4'h0, 1'b1, 1'b1, 1'b1, 12'h123, 12'h210, 1'b0, 2'd2, 1'b1, 1'b0};
        tbl[8]  = '{16'h0056, 4'h0, 1'b1, 1'b1, 1'b1, 12'h123, 12'h6B4, 1'b0, 2'd0, 1'b1, 1'b0};
        tbl[9]  = '{16'h7000, 4'h0, 1'b1, 1'b1, 1'b1, 12'h123, 12'hDD0, 1'b0, 2'd3, 1'b1, 1'b0};
        tbl[10] = '{16'h0080, 4'h0, 1'b1, 1'b1, 1'b1, 12'h123, 12'hFFF, 1'b0, 2'd1, 1'b1, 1'b0};
        tbl[11] = '{16'h0500, 4'h0, 1'b1, 1'b1, 1'b1, 12'h123, 12'h778, 1'b0, 2'd2, 1'b1, 1'b0};
        tbl[12] = '{16'h0100, 4'h4, 1'b1, 1'b1, 1'b1, 12'h123, 12'h8DF, 1'b0, 2'd2, 1'b1, 1'b0};
        tbl[13] = '{16'h0009, 4'h0, 1'b1, 1'b1, 1'b1, 12'h123, 12'hF0F, 1'b0, 2'd0, 1'b1, 1'b1};
        tbl[14] = '{16'h1111, 4'h0, 1'b0, 1'b1, 1'b1, 12'h123, 12'h000, 1'b0, 2'd0, 1'b1, 1'b0};
        tbl[15] = '{16'h0000, 4'h0, 1'b0, 1'b0, 1'b1, 12'h123, 12'h000, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[16] = '{16'h0000, 4'h0, 1'b1, 1'b1, 1'b1, 12'hABC, 12'h000, 1'b1, 2'd0, 1'b0, 1'b0};
        tbl[17] = '{16'h0000, 4'h0, 1'b1, 1'b1, 1'b1, 12'h5A5, 12'h000, 1'b1, 2'd0, 1'b0, 1'b0};
        tbl[18] = '{16'h0002, 4'h1, 1'b1, 1'b1, 1'b1, 12'h5A5, 12'h009, 1'b0, 2'd0, 1'b1, 1'b0};

        rst = 1'b1; pix_en = 1'b0; layer_idx = '0; layer_is_b = '0; bg_rgb = '0; cur_bg = '0;
        video_on_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        flash_req = 1'b0; flash_layer = 2'd0;
        repeat (2) @(posedge clk);
        #2;
        check("reset_outputs", 32'({dut_vec(), flash_busy}),
              32'({12'h000, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 8'd0, 1'b0}));
        rst = 1'b0;
        model_reset();

        // Table vectors.
        for (int v = 0; v < 19; v++) begin
            strobe(tbl[v].idx, tbl[v].isb, tbl[v].von, tbl[v].hs, tbl[v].vs, tbl[v].bg,
                   mk(tbl[v].exp_rgb, tbl[v].exp_use_bg, tbl[v].von, tbl[v].hs, tbl[v].vs,
                      tbl[v].exp_wl, tbl[v].exp_wv, tbl[v].exp_ill),
                   $sformatf("vec%0d", v), 1'b1);
        end

        // Stall with data in flight; garbage inputs must not be captured.
        strobe(16'h0400, 4'h0, 1'b1, 1'b1, 1'b1, 12'h0F0,
               mk(12'h210, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0), "pre_stall", 1'b1);
        strobe(16'h0000, 4'h0, 1'b1, 1'b0, 1'b1, 12'h0F0,
               mk(12'h000, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0), "hs_pulse", 1'b1);
        for (int k = 0; k < 10; k++) begin
            pix_en = 1'b0;
            layer_idx = 16'($urandom); layer_is_b = 4'($urandom);
            video_on_in = 1'($urandom); hsync_in = 1'($urandom); vsync_in = 1'($urandom);
            @(posedge clk);
            #1;
            check($sformatf("stall_hold%0d", k), 32'(dut_vec()), 32'(last_exp));
        end
        strobe(16'h0001, 4'h1, 1'b1, 1'b1, 1'b1, 12'h0F0,
               mk(12'h8DF, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0), "post_stall", 1'b1);
        blank(3, 1'b1);

        // 300 illegal pixels, frame edge, then a clean frame.
        for (int k = 0; k < 300; k++)
            strobe(16'h000C, 4'h0, 1'b1, 1'b1, 1'b1, cur_bg,
                   mk(12'hF0F, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1), "illegal", 1'b0);
        blank(1, 1'b1);
        blank(1, 1'b0);
        blank(3, 1'b1);
        check("bad_frame_saturated", 32'(bad_cnt_frame), 32'd255);
        for (int k = 0; k < 5; k++)
            strobe(16'h0003, 4'h0, 1'b1, 1'b1, 1'b1, cur_bg,
                   mk(12'hFF9, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0), "clean", 1'b0);
        blank(1, 1'b0);
        blank(3, 1'b1);
        check("bad_frame_clean", 32'(bad_cnt_frame), 32'd0);

        // Flash request on layer 2, then six frames.
        pix_en = 1'b0;
        flash_req = 1'b1; flash_layer = 2'd2;
        @(posedge clk);
        #1;
        flash_req = 1'b0;
        if (FLASH_ON) m_fstate = 1;
        check("flash_busy_after_req", 32'(flash_busy), 32'(FLASH_ON));
        for (int f = 0; f < 6; f++) begin
            flash_frame(f);
            if (f == 2) check("flash_busy_mid", 32'(flash_busy), 32'(FLASH_ON));
        end
        blank(3, 1'b1);
        check("flash_busy_done", 32'(flash_busy), 32'd0);

        // Reset mid-line while a non-idle pixel with hsync low is showing.
        strobe(16'h0300, 4'h0, 1'b1, 1'b1, 1'b1, cur_bg,
               mk(12'hFF9, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0), "pre_rst0", 1'b1);
        strobe(16'h0050, 4'h0, 1'b1, 1'b0, 1'b1, cur_bg,
               mk(12'h778, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0), "pre_rst1", 1'b1);
        strobe(16'h0300, 4'h0, 1'b1, 1'b0, 1'b1, cur_bg,
               mk(12'hFF9, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0), "pre_rst2", 1'b1);
        strobe(16'h0300, 4'h0, 1'b1, 1'b0, 1'b1, cur_bg,
               mk(12'hFF9, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0), "pre_rst3", 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("midline_reset", 32'({dut_vec(), flash_busy}),
              32'({12'h000, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 8'd0, 1'b0}));
        @(posedge clk);
        #3;
        rst = 1'b0;
        model_reset();
        for (int v = 3; v < 6; v++) begin
            strobe(tbl[v].idx, tbl[v].isb, tbl[v].von, tbl[v].hs, tbl[v].vs, tbl[v].bg,
                   mk(tbl[v].exp_rgb, tbl[v].exp_use_bg, tbl[v].von, tbl[v].hs, tbl[v].vs,
                      tbl[v].exp_wl, tbl[v].exp_wv, tbl[v].exp_ill),
                   $sformatf("post_rst_vec%0d", v), 1'b1);
        end
        blank(2, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sprite_layer_arbiter.md
Name: sprite_layer_arbiter

Overview:
- Per-pixel compositor and palette scheduler that sits between the sprite/tile layer fetch units and the VGA output stage.
- Each pixel strobe, NUM_LAYERS requesters each present a 4-bit palette index plus a team flag (is_b). The block picks the highest-priority non-transparent layer and converts its index to 12-bit RGB through the shared palette.
- It delays hsync/vsync/video_on so they stay aligned with the RGB output.
- It collects a per-frame count of illegal palette indices for debug.

Parameters:
- NUM_LAYERS, 4, number of requesting layers; layer 0 has the highest priority.
- LAYER_W, 2, width of winner-layer number; must be at least clog2(NUM_LAYERS).
- FLASH_FRAMES, 8, number of frames a flash lasts (FLASH_EN only); range 1..255.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- pix_en  in  1  pixel strobe; all pipeline state advances only when it is 1
- layer_idx  in  4*NUM_LAYERS  palette index per layer; layer i occupies bits [4i+3:4i]
- layer_is_b  in  NUM_LAYERS  team-B flag per layer
- bg_rgb  in  12  background colour used when every layer is transparent
- video_on_in, hsync_in, vsync_in  in  1 each  timing from the VGA sync generator; syncs are active-low
- flash_req  in  1  single-cycle flash request (used only with FLASH_EN)
- flash_layer  in  LAYER_W  layer to flash (used only with FLASH_EN)
- rgb_out  out  12  pixel colour, RRRRGGGGBBBB
- video_on_out, hsync_out, vsync_out  out  1 each  timing delayed to match rgb_out
- win_layer  out  LAYER_W  winning layer number; 0 when no layer wins
- win_valid  out  1  1 when a layer won (not background)
- bad_cnt_frame  out  8  illegal-index count latched for the previous frame
- flash_busy  out  1  flash state machine is not IDLE

Behaviour:
- Reset values: rgb_out=12'h000, hsync_out=1, vsync_out=1, video_on_out=0, win_layer=0, win_valid=0, bad_cnt_frame=0, flash_busy=0. All pipeline registers reset to the same idle values. Reset asserted mid-frame clears the pipeline immediately; the first valid output appears 3 strobes after release.
- Pipeline: 3 stages (A capture, B select, C colour). Latency is exactly 3 pix_en strobes from input to output for RGB, syncs and video_on. When pix_en=0, every register holds its value.
- Stage A: registers layer_idx, layer_is_b, video_on_in, hsync_in, vsync_in.
- Stage B: the winner is the lowest i with idx[i]!=0.
  - If there is no winner, win_valid=0 and win_layer=0.
  - Index 0 means transparent and never wins.
- Stage C, when video_on=0: rgb_out=000.
- Stage C, when video_on=1 and win_valid=0: rgb_out=bg_rgb. bg_rgb is sampled at stage C, not delayed.
- Stage C, when video_on=1 and win_valid=1, the palette maps the winner's index as follows:
  - 1 -> D42, or 8DF if is_b
  - 2 -> 921, or 009 if is_b
  - 3 -> FF9
  - 4 -> 210
  - 5 -> 778
  - 6 -> 6B4
  - 7 -> DD0
  - 8 -> FFF
  - 9..15 -> F0F (illegal)
- Illegal counter:
  - bad_cnt is 8 bits and saturates at 255. It increments on each stage-C strobe where video_on=1, win_valid=1 and idx>8.
  - On a stage-C vsync falling edge (previous stage-C vsync 1, new 0), bad_cnt_frame <= bad_cnt and bad_cnt <= 0 (+1 if the same strobe is itself illegal).
- Simultaneous layers with equal priority cannot occur: priority is strictly by index.

Optional Feature:
- Macro: SPRITE_FLASH_EN.
- With the macro: a state machine with states IDLE, ARMED and FLASH.
  - In IDLE, flash_req=1 latches flash_layer and moves to ARMED.
  - In ARMED, the next stage-C vsync falling edge loads frm_cnt=FLASH_FRAMES and moves to FLASH.
  - In FLASH, each vsync falling edge decrements frm_cnt; at 0 the machine returns to IDLE.
  - A flash_req in ARMED or FLASH re-latches the layer and returns to ARMED (restart).
  - While in FLASH with frm_cnt[0]=1, visible pixels whose win_layer equals the latched layer output FFF instead of the palette colour.
  - flash_busy = (state!=IDLE). The state machine advances on clk, independent of pix_en, except for edges derived from stage C.
- Without the macro: flash_req and flash_layer are ignored, flash_busy=0, and no flash logic is synthesised.

Decomposition:
- Shared package holds:
  - index constants IDX_TRANSPARENT=0 and IDX_MAX_LEGAL=8
  - the palette colour constants
  - the illegal colour F0F
  - the flash state enum
- One natural sub-module: palette_lut, purely combinational, mapping idx and is_b to rgb, instantiated in stage C.

Test Plan:
- Reset, then 3 strobes with all idx=0, video_on=1, bg_rgb=123 -> rgb_out=123, win_valid=0.
- Layers 0..3 idx={0,2,5,1}, is_b={0,1,0,0} -> after 3 strobes win_layer=1, rgb_out=009.
- pix_en held low 10 cycles mid-stream -> outputs frozen; on resume the next value appears at the correct strobe. hsync pulse is delayed exactly 3 strobes.
- 300 illegal pixels (idx=12) in a frame, then a vsync falling edge -> rgb_out=F0F during those pixels, bad_cnt_frame=255; next clean frame -> 0.
- Reset asserted mid-line -> outputs return to reset values in the same cycle; rgb_out=000, hsync_out=1.
- SPRITE_FLASH_EN, FLASH_FRAMES=4, flash_req on layer 2 -> ARMED until vsync fall. Then layer-2 pixels are FFF on frames with frm_cnt=3 and 1, palette colour on frames 4 and 2. After 4 vsync falls, flash_busy=0.
